// File: rtl/spi_flash_rd_seq.sv
// SPI flash read sequencer: configures the SPI block over the IO bus, streams a 0x03 read
// command plus dummy bytes through the MOSI FIFO and returns the MISO data bytes.
module spi_flash_rd_seq #(
  parameter logic [31:0] MODE_WORD = 32'h0000_0001,
  parameter logic [31:0] SDIV_WORD = 32'd4,
  parameter logic [15:0] TIMEOUT   = 16'd4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        busy,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        err,
  output logic        dma_io_we,
  output logic [13:0] dma_io_wadr,
  output logic [31:0] dma_io_wdata,
  output logic        dma_io_radr_en,
  output logic [13:0] dma_io_radr,
  input  logic [31:0] dma_io_rdata
);
  localparam logic [13:0] ADR_MODE = 14'h3C80;
  localparam logic [13:0] ADR_SDIV = 14'h3C81;
  localparam logic [13:0] ADR_MOSI = 14'h3C82;
  localparam logic [13:0] ADR_MISO = 14'h3C83;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_MODE, S_CFG_DIV, S_FLUSH, S_RD_MOSI,
    S_WT_MOSI, S_PUSH, S_RD_MISO, S_WT_MISO, S_FIN
  } state_t;

  state_t      r_state, w_next;
  logic [23:0] r_addr;
  logic [8:0]  r_len, r_tx_total, r_tx_cnt, r_popped, r_rx_cnt;
  logic [2:0]  r_rx_skip;
  logic [15:0] r_prog;
  logic        r_busy, r_done, r_err, r_rd_valid, r_we, r_re;
  logic [7:0]  r_rd_data;
  logic [13:0] r_wadr, r_radr;
  logic [31:0] r_wdata;

  logic        w_we, w_re, w_can_push, w_loop, w_pop, w_deliver, w_progress, w_timeout, w_unused;
  logic [13:0] w_wadr, w_radr;
  logic [31:0] w_wdata;
  logic [7:0]  w_tx_byte;
  logic [8:0]  w_outstanding, w_len_eff;

  assign w_unused      = &{1'b0, dma_io_rdata[31:10]};
  assign w_len_eff     = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
  assign w_outstanding = r_tx_cnt - r_popped;
  // Cap in-flight bytes at 6 so the 8-deep MISO FIFO can never overflow.
  assign w_can_push    = !dma_io_rdata[8] && (r_tx_cnt < r_tx_total) && (w_outstanding < 9'd6);
  assign w_loop        = (r_state == S_RD_MOSI) || (r_state == S_WT_MOSI) || (r_state == S_PUSH) ||
                         (r_state == S_RD_MISO) || (r_state == S_WT_MISO);
  assign w_pop         = (r_state == S_WT_MISO) && !dma_io_rdata[9];
  assign w_deliver     = w_pop && (r_rx_skip == 3'd0);
  assign w_progress    = (r_state == S_PUSH) || w_pop;
  assign w_timeout     = w_loop && !w_progress && (r_prog >= TIMEOUT);

  always_comb begin
    case (r_tx_cnt)
      9'd0:    w_tx_byte = 8'h03;
      9'd1:    w_tx_byte = r_addr[23:16];
      9'd2:    w_tx_byte = r_addr[15:8];
      9'd3:    w_tx_byte = r_addr[7:0];
      default: w_tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (req) w_next = S_CFG_MODE;
      S_CFG_MODE: w_next = S_CFG_DIV;
      S_CFG_DIV:  w_next = S_FLUSH;
      S_FLUSH:    w_next = S_RD_MOSI;
      S_RD_MOSI:  w_next = S_WT_MOSI;
      S_WT_MOSI:  w_next = w_can_push ? S_PUSH : S_RD_MISO;
      S_PUSH:     w_next = S_RD_MISO;
      S_RD_MISO:  w_next = S_WT_MISO;
      S_WT_MISO:  w_next = (w_deliver && (r_rx_cnt + 9'd1 == r_len)) ? S_FIN : S_RD_MOSI;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_FIN;
  end

  // Bus strobes are decoded from the next state so they register into the state they belong to.
  always_comb begin
    w_we    = 1'b0;
    w_wadr  = 14'h0;
    w_wdata = 32'h0;
    w_re    = 1'b0;
    w_radr  = 14'h0;
    case (w_next)
      S_CFG_MODE: begin w_we = 1'b1; w_wadr = ADR_MODE; w_wdata = MODE_WORD; end
      S_CFG_DIV:  begin w_we = 1'b1; w_wadr = ADR_SDIV; w_wdata = SDIV_WORD; end
      S_FLUSH:    begin w_we = 1'b1; w_wadr = ADR_MISO; w_wdata = 32'h0000_0400; end
      S_PUSH:     begin w_we = 1'b1; w_wadr = ADR_MOSI; w_wdata = {24'h0, w_tx_byte}; end
      S_RD_MOSI:  begin w_re = 1'b1; w_radr = ADR_MOSI; end
      S_RD_MISO:  begin w_re = 1'b1; w_radr = ADR_MISO; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= 24'h0;
      r_len      <= 9'h0;
      r_tx_total <= 9'h0;
      r_tx_cnt   <= 9'h0;
      r_popped   <= 9'h0;
      r_rx_cnt   <= 9'h0;
      r_rx_skip  <= 3'h0;
      r_prog     <= 16'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h0;
      r_we       <= 1'b0;
      r_wadr     <= 14'h0;
      r_wdata    <= 32'h0;
      r_re       <= 1'b0;
      r_radr     <= 14'h0;
    end else begin
      r_state    <= w_next;
      r_we       <= w_we;
      r_wadr     <= w_wadr;
      r_wdata    <= w_wdata;
      r_re       <= w_re;
      r_radr     <= w_radr;
      r_done     <= (w_next == S_FIN);
      r_rd_valid <= w_deliver;
      r_rd_data  <= w_deliver ? dma_io_rdata[7:0] : 8'h00;
      if (r_state == S_IDLE && req) begin
        r_addr     <= req_addr;
        r_len      <= w_len_eff;
        r_tx_total <= w_len_eff + 9'd4;
        r_tx_cnt   <= 9'h0;
        r_popped   <= 9'h0;
        r_rx_cnt   <= 9'h0;
        r_rx_skip  <= 3'd4;
        r_busy     <= 1'b1;
        r_err      <= 1'b0;
      end
      if (r_state == S_FIN) r_busy <= 1'b0;
      if (r_state == S_PUSH) r_tx_cnt <= r_tx_cnt + 9'd1;
      if (w_pop) begin
        r_popped <= r_popped + 9'd1;
        if (r_rx_skip != 3'd0) r_rx_skip <= r_rx_skip - 3'd1;
        else                   r_rx_cnt  <= r_rx_cnt + 9'd1;
      end
      if (!w_loop || w_progress) r_prog <= 16'h0;
      else                       r_prog <= r_prog + 16'd1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign busy           = r_busy;
  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_data;
  assign done           = r_done;
  assign err            = r_err;
  assign dma_io_we      = r_we;
  assign dma_io_wadr    = r_wadr;
  assign dma_io_wdata   = r_wdata;
  assign dma_io_radr_en = r_re;
  assign dma_io_radr    = r_radr;
endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Directed bench for spi_flash_rd_seq with a behavioural SPI block (MOSI/MISO FIFOs, fixed byte time).
module tb_spi_flash_rd_seq;
  localparam logic [13:0] ADR_MODE = 14'h3C80;
  localparam logic [13:0] ADR_MOSI = 14'h3C82;
  localparam logic [13:0] ADR_MISO = 14'h3C83;
  localparam int BYTE_T = 16;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [7:0]  req_len = 8'h0;
  logic        busy, rd_valid, done, err, dma_io_we, dma_io_radr_en;
  logic [7:0]  rd_data;
  logic [13:0] dma_io_wadr, dma_io_radr;
  logic [31:0] dma_io_wdata;
  logic [31:0] dma_io_rdata = 32'h0;

  spi_flash_rd_seq #(.MODE_WORD(32'h0000_0001), .SDIV_WORD(32'd4), .TIMEOUT(16'd100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
    .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
    .dma_io_radr_en(dma_io_radr_en), .dma_io_radr(dma_io_radr), .dma_io_rdata(dma_io_rdata));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Flash response for the k-th byte clocked out on MOSI (first 4 are command-phase junk).
  function automatic logic [7:0] resp(input int idx);
    logic [7:0] b;
    b = idx[7:0];
    if (idx < 4)  return 8'hFF;
    if (idx == 4) return 8'hA5;
    if (idx == 5) return 8'h5A;
    return b ^ 8'h3C;
  endfunction

  // SPI block model
  logic [7:0]  mosi_q[$], miso_q[$], mosi_log[$];
  logic [13:0] wr_adr_log[$];
  logic [31:0] wr_dat_log[$];
  int cyc = 0, stream_idx = 0, tick = 0, pushes = 0, pops = 0, max_out = 0;
  int mode_writes = 0, overflow = 0, last_push = 0;
  logic force_full = 1'b0, hold_empty = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (dma_io_we) begin
      if (dma_io_wadr == ADR_MODE) begin
        mosi_q.delete(); miso_q.delete(); mosi_log.delete();
        wr_adr_log.delete(); wr_dat_log.delete();
        stream_idx = 0; pushes = 0; pops = 0; max_out = 0; tick = 0;
        mode_writes++;
      end
      wr_adr_log.push_back(dma_io_wadr);
      wr_dat_log.push_back(dma_io_wdata);
      if (dma_io_wadr == ADR_MISO && dma_io_wdata == 32'h400) miso_q.delete();
      if (dma_io_wadr == ADR_MOSI) begin
        mosi_q.push_back(dma_io_wdata[7:0]);
        mosi_log.push_back(dma_io_wdata[7:0]);
        pushes++;
        last_push = cyc;
      end
    end
    if (dma_io_radr_en) begin
      if (dma_io_radr == ADR_MOSI)
        dma_io_rdata <= {22'h0, (mosi_q.size() == 0), (force_full || mosi_q.size() >= 8), 8'h00};
      else if (dma_io_radr == ADR_MISO) begin
        if (hold_empty || miso_q.size() == 0) dma_io_rdata <= {22'h0, 2'b10, 8'h00};
        else begin
          dma_io_rdata <= {22'h0, (miso_q.size() >= 8), 1'b0, 8'h00} | {24'h0, miso_q[0]};
          void'(miso_q.pop_front());
          pops++;
        end
      end else dma_io_rdata <= 32'h0;
    end
    tick++;
    if (tick >= BYTE_T && mosi_q.size() > 0) begin
      void'(mosi_q.pop_front());
      miso_q.push_back(resp(stream_idx));
      stream_idx++;
      tick = 0;
    end
    if (miso_q.size() > 8) overflow++;
    if (pushes - pops > max_out) max_out = pushes - pops;
  end

  // Output monitor
  logic [7:0] rx_log[$];
  int done_cnt = 0, done_cyc = 0, both_hi = 0, act_cnt = 0;

  always @(negedge clk) begin
    if (dma_io_we && dma_io_wadr == ADR_MODE) begin rx_log.delete(); done_cnt = 0; end
    if (rd_valid) rx_log.push_back(rd_data);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (dma_io_we && dma_io_radr_en) both_hi++;
    if (dma_io_we || dma_io_radr_en) act_cnt++;
  end

  task automatic start_txn(input logic [23:0] a, input logic [7:0] l);
    @(negedge clk);
    req = 1'b1; req_addr = a; req_len = l;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin ok = 1; break; end
    end
    check_eq(tag, ok, 1);
  endtask

  task automatic check_rx(input string tag, input int n);
    int mism;
    mism = 0;
    check_eq({tag, "_cnt"}, rx_log.size(), n);
    for (int j = 0; j < rx_log.size() && j < n; j++)
      if (rx_log[j] !== resp(j + 4)) mism++;
    check_eq({tag, "_data"}, mism, 0);
  endtask

  initial begin
    logic [7:0] exp39 [6];
    int base, ok;
    exp39 = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", {busy, rd_valid, done, err, dma_io_we, dma_io_radr_en}, 0);
    check_eq("rst_bus", dma_io_wdata | {18'h0, dma_io_wadr} | {18'h0, dma_io_radr} | {24'h0, rd_data}, 0);
    rst = 1'b0;

    // basic 2-byte read
    start_txn(24'h012345, 8'd2);
    check_eq("t39_busy", busy, 1);
    wait_done("t39_done", 500);
    check_eq("t39_cfg_adr0", wr_adr_log[0], 14'h3C80);
    check_eq("t39_cfg_dat0", wr_dat_log[0], 32'h1);
    check_eq("t39_cfg_adr1", wr_adr_log[1], 14'h3C81);
    check_eq("t39_cfg_dat1", wr_dat_log[1], 32'd4);
    check_eq("t39_cfg_adr2", wr_adr_log[2], 14'h3C83);
    check_eq("t39_cfg_dat2", wr_dat_log[2], 32'h400);
    check_eq("t39_mosi_n", mosi_log.size(), 6);
    for (int k = 0; k < 6 && k < mosi_log.size(); k++)
      check_eq($sformatf("t39_mosi%0d", k), mosi_log[k], exp39[k]);
    check_eq("t39_rx_n", rx_log.size(), 2);
    if (rx_log.size() >= 2) begin
      check_eq("t39_rx0", rx_log[0], 8'hA5);
      check_eq("t39_rx1", rx_log[1], 8'h5A);
    end
    check_eq("t39_err", err, 0);
    @(negedge clk);
    check_eq("t39_busy_off", busy, 0);
    repeat (10) @(negedge clk);
    check_eq("t39_one_done", done_cnt, 1);

    // len=0 means 256 bytes
    start_txn(24'hABCDEF, 8'd0);
    wait_done("t40_done", 9000);
    check_rx("t40_rx", 256);
    check_eq("t40_pushes", pushes, 260);
    check_eq("t40_max_out", (max_out <= 6), 1);
    check_eq("t40_cmd1", mosi_log[1], 8'hAB);
    check_eq("t40_cmd3", mosi_log[3], 8'hEF);
    check_eq("t40_err", err, 0);

    // MOSI forced full for 20 cycles
    force_full = 1'b1;
    start_txn(24'h000010, 8'd3);
    repeat (20) @(negedge clk);
    check_eq("t41_no_push", pushes, 0);
    force_full = 1'b0;
    wait_done("t41_done", 800);
    check_rx("t41_rx", 3);
    check_eq("t41_err", err, 0);

    // MISO never returns data -> timeout
    repeat (3) @(negedge clk);
    hold_empty = 1'b1;
    start_txn(24'h222222, 8'd4);
    wait_done("t42_done", 600);
    check_eq("t42_err", err, 1);
    check_eq("t42_pushes", pushes, 6);
    check_eq("t42_latency", (done_cyc - last_push <= 104), 1);
    check_eq("t42_rx_n", rx_log.size(), 0);
    @(negedge clk);
    check_eq("t42_busy_off", busy, 0);
    hold_empty = 1'b0;

    // reset during data phase
    start_txn(24'h100000, 8'd8);
    check_eq("t43_err_clr", err, 0);
    ok = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (rx_log.size() >= 2) begin ok = 1; break; end
    end
    check_eq("t43_in_data", ok, 1);
    #2 rst = 1'b1;
    base = act_cnt;
    @(negedge clk);
    check_eq("t43_rst_ctl", {busy, rd_valid, done, err, dma_io_we, dma_io_radr_en}, 0);
    check_eq("t43_rst_bus", dma_io_wdata | {18'h0, dma_io_wadr} | {18'h0, dma_io_radr}, 0);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("t43_quiet", act_cnt - base, 0);
    start_txn(24'h00FF10, 8'd3);
    wait_done("t43_done", 800);
    check_rx("t43_rx", 3);
    check_eq("t43_cmd2", mosi_log[2], 8'hFF);
    check_eq("t43_err", err, 0);

    // req while busy is ignored
    repeat (3) @(negedge clk);
    base = mode_writes;
    start_txn(24'h345678, 8'd2);
    repeat (3) @(negedge clk);
    req = 1'b1; req_addr = 24'h999999; req_len = 8'd9;
    @(negedge clk);
    req = 1'b0;
    repeat (20) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done("t44_done", 800);
    repeat (30) @(negedge clk);
    check_eq("t44_one_done", done_cnt, 1);
    check_eq("t44_one_cfg", mode_writes - base, 1);
    check_eq("t44_addr", mosi_log[1], 8'h34);
    check_rx("t44_rx", 2);

    check_eq("both_strobes", both_hi, 0);
    check_eq("miso_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
